cookie_count_display: RTL and testbench

- Upstream stage of the chip top. Turns one raw push-button (the "cookie click") into a 4-digit BCD cookie count.
- Shows that count on the single 7-segment output by scrolling digits one at a time, most significant first, then a blank gap.
- Its seg_out/dp_out drive uo_out[6:0]/uo_out[7] directly; the top adds no further logic.

---
 rtl/cookie_count_display_pkg.sv | 33 +++
 rtl/cookie_count_display_debounce.sv | 35 +++
 rtl/cookie_count_display.sv | 77 +++++++
 tb/tb_cookie_count_display.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cookie_count_display_pkg.sv
// cookie_count_display_pkg: shared state encodings, 7-segment glyphs and default timings
package cookie_count_display_pkg;
  typedef enum logic [2:0] {D3 = 3'd0, D2 = 3'd1, D1 = 3'd2, D0 = 3'd3, GAP = 3'd4} state_t;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam int DEF_DB_CYCLES = 100000;
  localparam int DEF_DIGIT_CYCLES = 5000000;
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: glyph = SEG_0;
      4'd1: glyph = SEG_1;
      4'd2: glyph = SEG_2;
      4'd3: glyph = SEG_3;
      4'd4: glyph = SEG_4;
      4'd5: glyph = SEG_5;
      4'd6: glyph = SEG_6;
      4'd7: glyph = SEG_7;
      4'd8: glyph = SEG_8;
      4'd9: glyph = SEG_9;
      default: glyph = SEG_DASH;
    endcase
  endfunction
endpackage

// File: rtl/cookie_count_display_debounce.sv
// cookie_count_display_debounce: 2-FF synchroniser, debounce timer and rising-edge click pulse
// Ports: clk, rst (sync, active-high), click_raw (async button), click_pulse (1-cycle, DB_CYCLES+3 after a clean edge)
module cookie_count_display_debounce
  import cookie_count_display_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int CNT_W = 23
) (
  input  logic clk,
  input  logic rst,
  input  logic click_raw,
  output logic click_pulse
);
  logic [1:0] sync;
  logic stable, stable_d;
  logic [CNT_W-1:0] timer;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      stable <= 1'b0;
      stable_d <= 1'b0;
      timer <= '0;
      click_pulse <= 1'b0;
    end else begin
      sync <= {sync[0], click_raw};
      stable_d <= stable;
      click_pulse <= stable & ~stable_d;
      if (sync[1] == stable) timer <= '0;
      else if (timer == CNT_W'(DB_CYCLES - 1)) begin
        stable <= sync[1];
        timer <= '0;
      end else timer <= timer + 1'b1;
    end
  end
endmodule

// File: rtl/cookie_count_display.sv
// cookie_count_display: debounced click counter in BCD, scrolled digit by digit onto one 7-segment display
// Ports: clk, rst (sync, active-high), ena (freezes counter and sequencer), click_raw, clear,
//        seg_out[6:0] (segments a..g), dp_out, count_bcd[15:0], overflow (sticky 9999->0000 wrap)
// Build option: LEADING_ZERO_BLANK_EN skips leading-zero digits at the start of each scroll
module cookie_count_display
  import cookie_count_display_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int DIGIT_CYCLES = DEF_DIGIT_CYCLES,
  parameter int CNT_W = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        click_raw,
  input  logic        clear,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic [15:0] count_bcd,
  output logic        overflow
);
  logic click_pulse;
  logic [15:0] inc;
  logic [4:0] carry;
  logic [15:0] disp;
  logic [CNT_W-1:0] slot;
  logic [3:0] digit;
  state_t state, first, next;
  cookie_count_display_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db (
    .clk(clk),
    .rst(rst),
    .click_raw(click_raw),
    .click_pulse(click_pulse)
  );
  always_comb begin
    inc = count_bcd;
    carry = 5'b00001;
    for (int i = 0; i < 4; i++) begin
      inc[4*i+:4] = carry[i] ? (count_bcd[4*i+:4] == 4'd9 ? 4'd0 : count_bcd[4*i+:4] + 4'd1) : count_bcd[4*i+:4];
      carry[i+1] = carry[i] & (count_bcd[4*i+:4] == 4'd9);
    end
  end
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_bcd <= '0;
      overflow <= 1'b0;
    end else if (ena && click_pulse) begin
      count_bcd <= inc;
      overflow <= overflow | carry[4];
    end
  end
`ifdef LEADING_ZERO_BLANK_EN
  assign first = count_bcd[15:12] != 4'd0 ? D3 : count_bcd[11:8] != 4'd0 ? D2 : count_bcd[7:4] != 4'd0 ? D1 : D0;
`else
  assign first = D3;
`endif
  assign next = state == GAP ? first : state == D0 ? GAP : state_t'(state + 3'd1);
  assign digit = state == D3 ? disp[15:12] : state == D2 ? disp[11:8] : state == D1 ? disp[7:4] : disp[3:0];
  // Outputs follow the state register, so they change one cycle after each transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= GAP;
      slot <= '0;
      disp <= '0;
      seg_out <= SEG_BLANK;
      dp_out <= 1'b0;
    end else if (ena) begin
      seg_out <= state == GAP ? SEG_BLANK : glyph(digit);
      dp_out <= state == GAP ? overflow : state == D0;
      if (slot == CNT_W'(DIGIT_CYCLES - 1)) begin
        slot <= '0;
        state <= next;
        if (state == GAP) disp <= count_bcd;
      end else slot <= slot + 1'b1;
    end
  end
endmodule

// File: tb/tb_cookie_count_display.sv
// tb_cookie_count_display: directed self-checking bench for the cookie counter and digit scroller
module tb_cookie_count_display;
  logic clk = 1'b0, rst = 1'b1, ena = 1'b1, clear = 1'b0, raw_s = 1'b0, raw_f = 1'b0;
  logic [6:0] seg_s, seg_f;
  logic dp_s, dp_f, ov_s, ov_f;
  logic [15:0] cnt_s, cnt_f;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  cookie_count_display #(.DB_CYCLES(4), .DIGIT_CYCLES(8), .CNT_W(4)) u_slow (
    .clk(clk), .rst(rst), .ena(ena), .click_raw(raw_s), .clear(clear),
    .seg_out(seg_s), .dp_out(dp_s), .count_bcd(cnt_s), .overflow(ov_s)
  );
  cookie_count_display #(.DB_CYCLES(1), .DIGIT_CYCLES(8), .CNT_W(4)) u_fast (
    .clk(clk), .rst(rst), .ena(ena), .click_raw(raw_f), .clear(clear),
    .seg_out(seg_f), .dp_out(dp_f), .count_bcd(cnt_f), .overflow(ov_f)
  );
  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic click_fast();
    raw_f = 1'b1;
    tick();
    raw_f = 1'b0;
    tick();
  endtask
  task automatic wait_d3_start(output bit ok);
    bit a = 0, b = 0;
    for (int i = 0; i < 100 && !a; i++) if (seg_f === 7'h00) a = 1; else tick();
    for (int i = 0; i < 100 && a && !b; i++) if (seg_f !== 7'h00) b = 1; else tick();
    ok = a & b;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick();
    tests++;
    if ({seg_s, dp_s, cnt_s, ov_s} !== 25'd0) begin
      fails++;
      $display("FAIL reset_slow got seg=%h dp=%b cnt=%h ov=%b want all zero", seg_s, dp_s, cnt_s, ov_s);
    end
    tests++;
    if ({seg_f, dp_f, cnt_f, ov_f} !== 25'd0) begin
      fails++;
      $display("FAIL reset_fast got seg=%h dp=%b cnt=%h ov=%b want all zero", seg_f, dp_f, cnt_f, ov_f);
    end
  endtask
  task automatic test_debounce_latency();
    tick(2);
    raw_s = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 7) begin
        tests++;
        if (cnt_s !== 16'h0000) begin fails++; $display("FAIL latency_early got %h want 0000", cnt_s); end
      end
      if (c == 8 || c == 20) begin
        tests++;
        if (cnt_s !== 16'h0001) begin fails++; $display("FAIL latency_c%0d got %h want 0001", c, cnt_s); end
      end
    end
    raw_s = 1'b0;
    tick(10);
  endtask
  task automatic test_bounce();
    for (int i = 0; i < 15; i++) begin
      raw_s = ~raw_s;
      tick(2);
    end
    raw_s = 1'b0;
    tick(12);
    tests++;
    if (cnt_s !== 16'h0001) begin fails++; $display("FAIL bounce got %h want 0001", cnt_s); end
  endtask
  task automatic test_overflow();
    bit ok;
    for (int n = 1; n <= 9999; n++) begin
      click_fast();
      if (n == 9 || n == 99 || n == 999 || n == 1234) begin
        tick(4);
        tests++;
        if (cnt_f !== to_bcd(n)) begin fails++; $display("FAIL carry_%0d got %h want %h", n, cnt_f, to_bcd(n)); end
      end
    end
    tick(4);
    tests++;
    if (cnt_f !== 16'h9999 || ov_f !== 1'b0) begin fails++; $display("FAIL preload got %h ov=%b want 9999 ov=0", cnt_f, ov_f); end
    click_fast();
    tick(4);
    tests++;
    if (cnt_f !== 16'h0000 || ov_f !== 1'b1) begin fails++; $display("FAIL wrap got %h ov=%b want 0000 ov=1", cnt_f, ov_f); end
    for (int i = 0; i < 100 && seg_f !== 7'h00; i++) tick();
    tests++;
    if (seg_f !== 7'h00 || dp_f !== 1'b1) begin fails++; $display("FAIL gap_dp got seg=%h dp=%b want 00 dp=1", seg_f, dp_f); end
    raw_f = 1'b1;
    tick();
    raw_f = 1'b0;
    tick(3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    tests++;
    if (cnt_f !== 16'h0000 || ov_f !== 1'b0) begin fails++; $display("FAIL clear_vs_click got %h ov=%b want 0000 ov=0", cnt_f, ov_f); end
    ok = 1;
  endtask
  task automatic test_display();
    logic [6:0] exp [5] = '{7'h06, 7'h5B, 7'h3F, 7'h07, 7'h00};
    bit ok, bad;
    logic [7:0] got;
    for (int n = 0; n < 1207; n++) click_fast();
    tick(4);
    tests++;
    if (cnt_f !== 16'h1207) begin fails++; $display("FAIL count_1207 got %h want 1207", cnt_f); end
    wait_d3_start(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL scroll_sync got timeout want D3 start"); end
    for (int s = 0; s < 5; s++) begin
      bad = 0;
      got = 0;
      for (int k = 0; k < 8; k++) begin
        if (!bad && (seg_f !== exp[s] || dp_f !== (s == 3))) begin bad = 1; got = {dp_f, seg_f}; end
        tick();
      end
      tests++;
      if (bad) begin fails++; $display("FAIL scroll_slot%0d got dp=%b seg=%h want dp=%b seg=%h", s, got[7], got[6:0], s == 3, exp[s]); end
    end
  endtask
  task automatic test_midscroll_ena();
    logic [6:0] exp [7] = '{7'h5B, 7'h3F, 7'h07, 7'h00, 7'h06, 7'h5B, 7'h3F};
    bit ok, bad;
    logic [7:0] got;
    wait_d3_start(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL mid_sync got timeout want D3 start"); end
    raw_f = 1'b1;
    tick();
    raw_f = 1'b0;
    tick(7);
    for (int s = 0; s < 7; s++) begin
      bad = 0;
      got = 0;
      for (int k = 0; k < 8; k++) begin
        if (!bad && (seg_f !== exp[s] || dp_f !== (s == 2))) begin bad = 1; got = {dp_f, seg_f}; end
        tick();
      end
      tests++;
      if (bad) begin fails++; $display("FAIL mid_slot%0d got dp=%b seg=%h want dp=%b seg=%h", s, got[7], got[6:0], s == 2, exp[s]); end
    end
    tests++;
    if (cnt_f !== 16'h1208) begin fails++; $display("FAIL mid_count got %h want 1208", cnt_f); end
    bad = 0;
    got = 0;
    for (int k = 0; k < 2; k++) begin
      if (!bad && (seg_f !== 7'h7F || dp_f !== 1'b1)) begin bad = 1; got = {dp_f, seg_f}; end
      tick();
    end
    ena = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!bad && (seg_f !== 7'h7F || dp_f !== 1'b1)) begin bad = 1; got = {dp_f, seg_f}; end
      raw_f = (k == 1);
      tick();
    end
    ena = 1'b1;
    raw_f = 1'b0;
    tests++;
    if (bad) begin fails++; $display("FAIL freeze_hold got dp=%b seg=%h want dp=1 seg=7f", got[7], got[6:0]); end
    tests++;
    if (cnt_f !== 16'h1208) begin fails++; $display("FAIL freeze_drop got %h want 1208", cnt_f); end
    tick(5);
    tests++;
    if (seg_f !== 7'h7F) begin fails++; $display("FAIL resume_d0 got %h want 7f", seg_f); end
    tick();
    tests++;
    if (seg_f !== 7'h00 || dp_f !== 1'b0) begin fails++; $display("FAIL resume_gap got seg=%h dp=%b want 00 dp=0", seg_f, dp_f); end
  endtask
`ifdef LEADING_ZERO_BLANK_EN
  task automatic test_lzb();
    logic [6:0] exp_a [4] = '{7'h66, 7'h5B, 7'h00, 7'h66};
    logic [6:0] exp_b [3] = '{7'h3F, 7'h00, 7'h3F};
    bit ok, bad;
    logic [7:0] got;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int n = 0; n < 42; n++) click_fast();
    tick(4);
    tests++;
    if (cnt_f !== 16'h0042) begin fails++; $display("FAIL lzb_count got %h want 0042", cnt_f); end
    wait_d3_start(ok);
    for (int s = 0; s < 4; s++) begin
      bad = !ok;
      got = 0;
      for (int k = 0; k < 8; k++) begin
        if (!bad && (seg_f !== exp_a[s] || dp_f !== (s == 1))) begin bad = 1; got = {dp_f, seg_f}; end
        tick();
      end
      tests++;
      if (bad) begin fails++; $display("FAIL lzb42_slot%0d got dp=%b seg=%h want dp=%b seg=%h", s, got[7], got[6:0], s == 1, exp_a[s]); end
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    wait_d3_start(ok);
    for (int s = 0; s < 3; s++) begin
      bad = !ok;
      got = 0;
      for (int k = 0; k < 8; k++) begin
        if (!bad && (seg_f !== exp_b[s] || dp_f !== (s != 1))) begin bad = 1; got = {dp_f, seg_f}; end
        tick();
      end
      tests++;
      if (bad) begin fails++; $display("FAIL lzb0_slot%0d got dp=%b seg=%h want dp=%b seg=%h", s, got[7], got[6:0], s != 1, exp_b[s]); end
    end
  endtask
`endif
  initial begin
    #900000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_debounce_latency();
    test_bounce();
    test_overflow();
    test_display();
    test_midscroll_ena();
`ifdef LEADING_ZERO_BLANK_EN
    test_lzb();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
